// File: rtl/decode_pkg.sv
// decode_pkg: instruction field layout and register-address legality helper for the decode stage
package decode_pkg;
    localparam int OPCODE_W = 7;
    localparam int RADDR_W  = 5;
    localparam int OFF_W    = 10;
    localparam int OP_MSB   = 31;
    localparam int OP_LSB   = 25;
    localparam int DST_MSB  = 24;
    localparam int DST_LSB  = 20;
    localparam int S1_MSB   = 19;
    localparam int S1_LSB   = 15;
    localparam int S2_MSB   = 14;
    localparam int S2_LSB   = 10;
    localparam int OFF_MSB  = 9;
    localparam int OFF_LSB  = 0;

    // An address names a real, writable register: inside the file and not a hardwired r0
    function automatic logic reg_ok(input logic [RADDR_W-1:0] a, input int nregs, input bit r0z);
        return ({1'b0, a} < 6'(nregs)) && !(r0z && a == '0);
    endfunction
endpackage

// File: rtl/decode_stage_p_if.sv
// decode_stage_p_if: fetch-side, writeback and execute-side signals of the decode stage
interface decode_stage_p_if #(parameter int XLEN = 32);
    import decode_pkg::*;
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         instruction;
    logic                wb_en;
    logic [RADDR_W-1:0]  wb_addr;
    logic [XLEN-1:0]     wb_data;
    logic                flush;
    logic                out_valid;
    logic                out_ready;
    logic [OPCODE_W-1:0] opcode;
    logic [RADDR_W-1:0]  dst;
    logic [XLEN-1:0]     src1;
    logic [XLEN-1:0]     src2;
    logic [OFF_W-1:0]    offsetlo;
    logic [RADDR_W-1:0]  src1_addr;
    logic [RADDR_W-1:0]  src2_addr;

    modport slave (
        input  in_valid, instruction, wb_en, wb_addr, wb_data, flush, out_ready,
        output in_ready, out_valid, opcode, dst, src1, src2, offsetlo, src1_addr, src2_addr
    );
    modport master (
        output in_valid, instruction, wb_en, wb_addr, wb_data, flush, out_ready,
        input  in_ready, out_valid, opcode, dst, src1, src2, offsetlo, src1_addr, src2_addr
    );
endinterface

// File: rtl/decode_regfile.sv
// decode_regfile: NREGS x XLEN register file, two async read ports, one write port, zero rules
module decode_regfile
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter bit R0_ZERO = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we,
    input  logic [RADDR_W-1:0] wa,
    input  logic [XLEN-1:0]    wd,
    input  logic [RADDR_W-1:0] ra1,
    output logic [XLEN-1:0]    rd1,
    input  logic [RADDR_W-1:0] ra2,
    output logic [XLEN-1:0]    rd2
);
    localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

    logic [XLEN-1:0] mem [NREGS];

    // Illegal addresses never index the array, so the truncated index is only used in range
    assign rd1 = reg_ok(ra1, NREGS, R0_ZERO) ? mem[ra1[AW-1:0]] : '0;
    assign rd2 = reg_ok(ra2, NREGS, R0_ZERO) ? mem[ra2[AW-1:0]] : '0;

    // Clear on reset; commit only legal writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) mem[i] <= '0;
        end else if (we && reg_ok(wa, NREGS, R0_ZERO)) begin
            mem[wa[AW-1:0]] <= wd;
        end
    end
endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: registered instruction decode with operand read, writeback bypass and valid/ready flow control
module decode_stage_p
    import decode_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NREGS   = 32,
    parameter bit R0_ZERO = 1
) (
    input logic             clk,
    input logic             rst_n,
    decode_stage_p_if.slave bus
);
    logic               live, cap, stall, wb_ok;
    logic [RADDR_W-1:0] ra1, ra2;
    logic [XLEN-1:0]    rd1, rd2, op1, op2;

    assign ra1          = bus.instruction[S1_MSB:S1_LSB];
    assign ra2          = bus.instruction[S2_MSB:S2_LSB];
    assign bus.in_ready = live && !bus.flush && (!bus.out_valid || bus.out_ready);
    assign cap          = bus.in_valid && bus.in_ready;
    assign stall        = bus.out_valid && !bus.out_ready;
    assign wb_ok        = bus.wb_en && reg_ok(bus.wb_addr, NREGS, R0_ZERO);

    decode_regfile #(.XLEN(XLEN), .NREGS(NREGS), .R0_ZERO(R0_ZERO)) u_rf (
        .clk  (clk),
        .rst_n(rst_n),
        .we   (bus.wb_en),
        .wa   (bus.wb_addr),
        .wd   (bus.wb_data),
        .ra1  (ra1),
        .rd1  (rd1),
        .ra2  (ra2),
        .rd2  (rd2)
    );

    // Forward a same-edge writeback so a captured operand never sees the stale entry
    always_comb begin
        op1 = (wb_ok && bus.wb_addr == ra1) ? bus.wb_data : rd1;
        op2 = (wb_ok && bus.wb_addr == ra2) ? bus.wb_data : rd2;
    end

    // EMPTY/FULL bit plus bundle fields; flush wins, then capture, then drain; stalled operands track writebacks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live          <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.opcode    <= '0;
            bus.dst       <= '0;
            bus.src1      <= '0;
            bus.src2      <= '0;
            bus.offsetlo  <= '0;
            bus.src1_addr <= '0;
            bus.src2_addr <= '0;
        end else begin
            live <= 1'b1;
            if (bus.flush) begin
                bus.out_valid <= 1'b0;
            end else if (cap) begin
                bus.out_valid <= 1'b1;
                bus.opcode    <= bus.instruction[OP_MSB:OP_LSB];
                bus.dst       <= bus.instruction[DST_MSB:DST_LSB];
                bus.src1      <= op1;
                bus.src2      <= op2;
                bus.offsetlo  <= bus.instruction[OFF_MSB:OFF_LSB];
                bus.src1_addr <= ra1;
                bus.src2_addr <= ra2;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (stall && wb_ok && bus.wb_addr == bus.src1_addr) bus.src1 <= bus.wb_data;
            if (stall && wb_ok && bus.wb_addr == bus.src2_addr) bus.src2 <= bus.wb_data;
        end
    end
endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: directed checks of capture, bypass, stall refresh, zero rules, flush and back-to-back flow
module tb_decode_stage_p;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    decode_stage_p_if #(.XLEN(32)) bus ();

    decode_stage_p #(.XLEN(32), .NREGS(16), .R0_ZERO(1'b1)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ins(input int op, input int d, input int s1, input int s2, input int off);
        return {7'(op), 5'(d), 5'(s1), 5'(s2), 10'(off)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input int a, input logic [31:0] d);
        bus.wb_en   = 1'b1;
        bus.wb_addr = 5'(a);
        bus.wb_data = d;
    endtask

    task automatic test_reset();
        #1;
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %h exp 0", bus.out_valid); end
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got %h exp 0", bus.in_ready); end
        tests++; if (bus.opcode !== 7'h0 || bus.src1 !== 32'h0) begin fails++; $display("FAIL reset_fields got %h/%h exp 0/0", bus.opcode, bus.src1); end
        step();
        rst_n = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL release_in_ready got %h exp 0", bus.in_ready); end
        step();
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL live_in_ready got %h exp 1", bus.in_ready); end
    endtask

    task automatic test_capture();
        wb(3, 32'h11); step();
        wb(4, 32'h22); step();
        bus.wb_en = 1'b0;
        bus.instruction = ins(7'h15, 5, 3, 4, 10'h3FF);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL cap_valid got %h exp 1", bus.out_valid); end
        tests++; if (bus.opcode !== 7'h15 || bus.dst !== 5'd5) begin fails++; $display("FAIL cap_op_dst got %h/%h exp 15/05", bus.opcode, bus.dst); end
        tests++; if (bus.src1 !== 32'h11 || bus.src2 !== 32'h22) begin fails++; $display("FAIL cap_srcs got %h/%h exp 11/22", bus.src1, bus.src2); end
        tests++; if (bus.offsetlo !== 10'h3FF || bus.src1_addr !== 5'd3 || bus.src2_addr !== 5'd4) begin fails++; $display("FAIL cap_off_addr got %h/%h/%h exp 3ff/03/04", bus.offsetlo, bus.src1_addr, bus.src2_addr); end
        step();
        tests++; if (bus.out_valid !== 1'b0 || bus.opcode !== 7'h15) begin fails++; $display("FAIL drain got %h/%h exp 0/15", bus.out_valid, bus.opcode); end
    endtask

    task automatic test_bypass();
        bus.instruction = ins(7'h01, 1, 7, 7, 10'h12);
        bus.in_valid = 1'b1;
        wb(7, 32'hDEAD);
        step();
        bus.wb_en = 1'b0;
        tests++; if (bus.src1 !== 32'hDEAD || bus.src2 !== 32'hDEAD) begin fails++; $display("FAIL bypass got %h/%h exp dead/dead", bus.src1, bus.src2); end
        bus.instruction = ins(7'h02, 2, 7, 0, 0);
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.opcode !== 7'h02 || bus.src1 !== 32'hDEAD || bus.src2 !== 32'h0) begin fails++; $display("FAIL bypass_stored got %h/%h/%h exp 02/dead/0", bus.opcode, bus.src1, bus.src2); end
        step();
    endtask

    task automatic test_stall();
        bus.instruction = ins(7'h33, 6, 3, 9, 10'h055);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        tests++; if (bus.out_valid !== 1'b1 || bus.src2 !== 32'h0) begin fails++; $display("FAIL stall_cap got %h/%h exp 1/0", bus.out_valid, bus.src2); end
        step();
        bus.instruction = ins(7'h34, 7, 4, 3, 10'h1);
        bus.in_valid = 1'b1;
        wb(9, 32'h55);
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got %h exp 0", bus.in_ready); end
        step();
        bus.wb_en = 1'b0;
        tests++; if (bus.src2 !== 32'h55 || bus.src1 !== 32'h11) begin fails++; $display("FAIL refresh got %h/%h exp 55/11", bus.src2, bus.src1); end
        tests++; if (bus.opcode !== 7'h33 || bus.dst !== 5'd6 || bus.out_valid !== 1'b1) begin fails++; $display("FAIL stall_hold got %h/%h/%h exp 33/06/1", bus.opcode, bus.dst, bus.out_valid); end
        bus.out_ready = 1'b1;
        #1;
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL release_ready got %h exp 1", bus.in_ready); end
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.opcode !== 7'h34 || bus.src1 !== 32'h22 || bus.src2 !== 32'h11) begin fails++; $display("FAIL accept got %h/%h/%h exp 34/22/11", bus.opcode, bus.src1, bus.src2); end
        step();
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL one_accept got %h exp 0", bus.out_valid); end
    endtask

    task automatic test_zero();
        wb(0, 32'hFFFF); step();
        wb(20, 32'hBEEF); step();
        bus.instruction = ins(7'h40, 0, 0, 20, 0);
        bus.in_valid = 1'b1;
        wb(0, 32'h77);
        step();
        tests++; if (bus.src1 !== 32'h0 || bus.src2 !== 32'h0) begin fails++; $display("FAIL r0_oob got %h/%h exp 0/0", bus.src1, bus.src2); end
        bus.instruction = ins(7'h41, 0, 4, 20, 0);
        wb(20, 32'h99);
        step();
        bus.in_valid = 1'b0; bus.wb_en = 1'b0;
        tests++; if (bus.src1 !== 32'h22 || bus.src2 !== 32'h0) begin fails++; $display("FAIL oob_write got %h/%h exp 22/0", bus.src1, bus.src2); end
        step();
    endtask

    task automatic test_flush();
        bus.instruction = ins(7'h50, 1, 3, 4, 0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        step();
        bus.flush = 1'b1; bus.in_valid = 1'b1;
        bus.instruction = ins(7'h51, 2, 3, 4, 0);
        wb(10, 32'hABC);
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready got %h exp 0", bus.in_ready); end
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0; bus.wb_en = 1'b0;
        tests++; if (bus.out_valid !== 1'b0 || bus.opcode !== 7'h50) begin fails++; $display("FAIL flush_drop got %h/%h exp 0/50", bus.out_valid, bus.opcode); end
        bus.out_ready = 1'b1;
        bus.instruction = ins(7'h52, 0, 10, 0, 0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.src1 !== 32'hABC || bus.opcode !== 7'h52) begin fails++; $display("FAIL flush_wb got %h/%h exp abc/52", bus.src1, bus.opcode); end
        step();
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.instruction = ins(7'h60 + i, i, 3, 4, i);
            bus.in_valid = 1'b1;
            step();
            tests++; if (bus.out_valid !== 1'b1 || bus.opcode !== 7'(7'h60 + i) || bus.offsetlo !== 10'(i) || bus.src1 !== 32'h11) begin fails++; $display("FAIL b2b_%0d got %h/%h/%h/%h exp 1/%h/%h/11", i, bus.out_valid, bus.opcode, bus.offsetlo, bus.src1, 7'(7'h60 + i), 10'(i)); end
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.out_valid !== 1'b0 || bus.opcode !== 7'h0) begin fails++; $display("FAIL midreset got %h/%h exp 0/0", bus.out_valid, bus.opcode); end
        bus.in_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        bus.instruction = ins(7'h70, 0, 3, 4, 0);
        bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        tests++; if (bus.out_valid !== 1'b1 || bus.src1 !== 32'h0 || bus.src2 !== 32'h0) begin fails++; $display("FAIL rf_cleared got %h/%h/%h exp 1/0/0", bus.out_valid, bus.src1, bus.src2); end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.instruction = '0; bus.wb_en = 1'b0; bus.wb_addr = '0;
        bus.wb_data = '0; bus.flush = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_capture();
        test_bypass();
        test_stall();
        test_zero();
        test_flush();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/decode_stage_p.md
Name: decode_stage_p

Overview:
- Parametrised successor to the single-cycle decode stage.
- Splits a 32-bit instruction into opcode, dst, src1, src2 and offsetlo, and reads two operands from an internal register file.
- Adds a writeback port with same-cycle bypass, a valid/ready handshake with stall and flush, and an optional hardwired-zero r0.
- Sits between fetch and execute; writeback comes from the end of the pipeline.

Parameters:
XLEN, 32, operand/register data width (8..64)
NREGS, 32, number of architectural registers (2..32; address fields stay 5 bits)
R0_ZERO, 1, 1 = register 0 reads as zero and ignores writes

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  instruction valid from fetch
in_ready  out  1  stage can accept instruction this cycle
instruction  in  32  [31:25] opcode, [24:20] dst, [19:15] src1 addr, [14:10] src2 addr, [9:0] offsetlo
wb_en  in  1  register-file write enable
wb_addr  in  5  write address
wb_data  in  XLEN  write data
flush  in  1  discard held and incoming instruction
out_valid  out  1  decoded bundle valid
out_ready  in  1  execute accepts bundle
opcode  out  7  registered instruction[31:25]
dst  out  5  registered instruction[24:20]
src1  out  XLEN  operand for src1 address
src2  out  XLEN  operand for src2 address
offsetlo  out  10  registered instruction[9:0]
src1_addr  out  5  registered instruction[19:15]
src2_addr  out  5  registered instruction[14:10]

Behaviour:
- Reset (rst_n low, async):
  - All outputs 0, including out_valid.
  - All NREGS registers cleared to 0.
  - in_ready is 0 during reset and follows the rule below from the first edge after release.
- in_ready = !flush && (!out_valid || out_ready). Purely combinational; no loop through in_valid.
- Capture: if in_valid && in_ready on an edge, all output fields load from the instruction and out_valid=1.
  - Latency: one cycle, instruction to bundle.
- Drain: if out_valid && out_ready && !(in_valid && in_ready), then out_valid=0 and the data outputs hold their last values.
- Stall: if out_valid && !out_ready, all fields hold, except the held-operand refresh below.
- Held-operand refresh: while stalled, a legal write (wb_en, wb_addr==srcN_addr) updates srcN to wb_data at the same edge. Both srcs may refresh at once.
- Flush:
  - out_valid=0 at the next edge and in_ready=0 in the flush cycle, so any same-cycle input is dropped.
  - Flush has priority over capture and drain.
  - Writebacks during flush still commit.
- Register-file read:
  - An address >= NREGS reads 0.
  - Address 0 reads 0 when R0_ZERO=1.
- Register-file write:
  - Commits on the edge when wb_en=1.
  - Ignored if wb_addr >= NREGS, or wb_addr==0 with R0_ZERO=1.
- Bypass: on a capture edge with a legal write whose wb_addr equals src1 or src2 address, that operand takes wb_data, not the old entry. Both operands bypass if both match.
- Width: data is XLEN bits throughout; no extension or truncation. The offset is passed raw; sign extension is execute's job.
- No internal FSM beyond the out_valid bit. The states are EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY -> FULL on capture.
  - FULL -> EMPTY on drain or flush.
  - FULL -> FULL on accept+capture or stall.

Decomposition:
- Package decode_pkg: instruction field msb/lsb constants, OPCODE_W=7, RADDR_W=5, OFF_W=10.
- Sub-module decode_regfile (XLEN, NREGS, R0_ZERO): two async read ports, one write port, with the legality and zero rules. Bypass muxing stays in decode_stage_p.

Test Plan:
- Reset, then wb 0x11->r3 and 0x22->r4 over two cycles. Then instruction opcode=0x15, dst=5, src1=3, src2=4, offsetlo=0x3FF with in_valid=1 and out_ready=1 -> next cycle out_valid=1, opcode=0x15, dst=5, src1=0x11, src2=0x22, offsetlo=0x3FF.
- Bypass: in the capture cycle of an instruction with src1=7 and src2=7, drive wb r7<=0xDEAD -> both src1 and src2 = 0xDEAD; r7 reads 0xDEAD afterwards.
- Stall and refresh: out_ready=0 with the bundle held (src2 addr=9), then wb r9<=0x55 -> src2 becomes 0x55 next cycle, other fields unchanged, in_ready=0. Releasing out_ready gives one accept.
- R0_ZERO=1: wb r0<=0xFFFF, then read src1=0 -> src1=0. With NREGS=16, read src2 addr=20 -> src2=0, and wb to r20 has no effect.
- Flush: bundle held with out_ready=0, then assert flush together with in_valid=1 -> next cycle out_valid=0 and the input is not captured. A wb in the same cycle still commits.
- Back-to-back: 4 consecutive instructions with in_valid=1 and out_ready=1 -> 4 consecutive valid bundles with no bubbles, in order. Assert rst_n low mid-stream -> out_valid=0 immediately and the register file reads 0.
